// File: rtl/tdm_demux_4b.sv
// Receive side of a time-multiplexed A/B word bus: pairs an SYNC-flagged A word
// with the following B word and presents them as registered QA/QB with a PAIR_VLD strobe.
module tdm_demux_4b #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E_L,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VLD,
    input  logic             SYNC,
    input  logic             ERR_CLR,
    output logic [WIDTH-1:0] QA,
    output logic [WIDTH-1:0] QB,
    output logic             PAIR_VLD,
    output logic             PHASE,
    output logic             ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {HUNT = 1'b0, WAIT_B = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, qa_q, qb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pair_vld_q, err_q;

    // D_VLD is a one-way valid with no backpressure: a word is consumed on any
    // rising CLK where E_L=0 and D_VLD=1, and is ignored otherwise.
    logic accept, timeout_hit, load_a, pair_done, err_set;

    assign accept      = !E_L && D_VLD;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
    assign load_a      = accept && SYNC;
    assign pair_done   = accept && !SYNC && (state_q == WAIT_B);
    assign err_set     = (accept && (state_q == HUNT) && !SYNC)
                       || (accept && (state_q == WAIT_B) && SYNC)
                       || (!E_L && !D_VLD && (state_q == WAIT_B) && timeout_hit);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= HUNT;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (E_L) begin
            state_d = HUNT;
        end else begin
            case (state_q)
                HUNT:    if (accept && SYNC) state_d = WAIT_B;
                WAIT_B: begin
                    if (accept && !SYNC)            state_d = HUNT;
                    else if (!accept && timeout_hit) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Datapath and status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q     <= '0;
            qa_q       <= '0;
            qb_q       <= '0;
            cnt_q      <= '0;
            pair_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (load_a) hold_q <= D;
            if (pair_done) begin
                qa_q <= hold_q;
                qb_q <= D;
            end
            // Counter only advances while idling in WAIT_B; abort resets it, so it never wraps.
            if (E_L || (state_q == HUNT) || load_a || (state_d == HUNT))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_W'(1);
            pair_vld_q <= pair_done;
            err_q      <= err_set || (err_q && !ERR_CLR);
        end
    end

    // Output logic: stored pair is hidden, not lost, while disabled
    always_comb begin
        QA       = E_L ? '0 : qa_q;
        QB       = E_L ? '0 : qb_q;
        PAIR_VLD = !E_L && pair_vld_q;
        PHASE    = (state_q == WAIT_B);
        ERR      = err_q;
    end

endmodule

// File: tb/tb_tdm_demux_4b.sv
// Bench for tdm_demux_4b: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural pairing model.
module tb_tdm_demux_4b;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             E_L = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic             D_VLD = 1'b0;
    logic             SYNC = 1'b0;
    logic             ERR_CLR = 1'b0;
    logic [WIDTH-1:0] QA, QB;
    logic             PAIR_VLD, PHASE, ERR;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: "waiting for B" flag, pending A word, idle cycles since A
    bit               m_waiting;
    logic [WIDTH-1:0] m_pending, m_qa, m_qb;
    bit               m_pv, m_err;
    int               m_idle;

    tdm_demux_4b #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .E_L(E_L), .D(D), .D_VLD(D_VLD), .SYNC(SYNC),
        .ERR_CLR(ERR_CLR), .QA(QA), .QB(QB), .PAIR_VLD(PAIR_VLD), .PHASE(PHASE), .ERR(ERR)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_waiting = 0; m_pending = '0; m_qa = '0; m_qb = '0;
        m_pv = 0; m_err = 0; m_idle = 0;
    endtask

    task automatic model_update();
        bit err_event;
        err_event = 0;
        m_pv = 0;
        if (RST) begin
            model_reset();
            return;
        end
        if (E_L) begin
            m_waiting = 0;
            m_idle = 0;
        end else if (D_VLD) begin
            if (!m_waiting && SYNC) begin
                m_pending = D; m_waiting = 1; m_idle = 0;
            end else if (!m_waiting) begin
                err_event = 1;
            end else if (!SYNC) begin
                m_qa = m_pending; m_qb = D; m_pv = 1; m_waiting = 0;
            end else begin
                m_pending = D; m_idle = 0; err_event = 1;
            end
        end else if (m_waiting) begin
            m_idle++;
            if (m_idle > TIMEOUT) begin
                err_event = 1; m_waiting = 0;
            end
        end
        if (err_event)    m_err = 1;
        else if (ERR_CLR) m_err = 0;
    endtask

    // Driver: inputs change just after the falling edge, model advances at the rising edge
    task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic v,
                        input logic s, input logic c, input logic r);
        @(negedge CLK);
        #1;
        E_L = e; D = d; D_VLD = v; SYNC = s; ERR_CLR = c; RST = r;
        @(posedge CLK);
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 0, 0, 0, 0);
    endtask

    // Scoreboard compare on every falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("qa",       QA,              E_L ? 4'h0 : m_qa);
            check("qb",       QB,              E_L ? 4'h0 : m_qb);
            check("pair_vld", {3'b0, PAIR_VLD}, {3'b0, (!E_L && m_pv)});
            check("phase",    {3'b0, PHASE},    {3'b0, m_waiting});
            check("err",      {3'b0, ERR},      {3'b0, m_err});
        end
    end

    initial begin
        model_reset();
        // 1: reset with an active-looking word on the bus
        step(0, 4'hF, 1, 1, 0, 1);
        step(0, 4'hF, 1, 1, 0, 1);
        #1;
        check("rst_qa", QA, 4'h0);
        check("rst_qb", QB, 4'h0);
        check("rst_pv", {3'b0, PAIR_VLD}, 4'h0);
        check("rst_err", {3'b0, ERR}, 4'h0);
        check("rst_phase", {3'b0, PHASE}, 4'h0);
        chk_en = 1'b1;
        idle(1);

        // 2: normal pair
        step(0, 4'b1010, 1, 1, 0, 0);
        #1 check("t2_phase", {3'b0, PHASE}, 4'h1);
        step(0, 4'b0101, 1, 0, 0, 0);
        #1;
        check("t2_qa", QA, 4'b1010);
        check("t2_qb", QB, 4'b0101);
        check("t2_pv", {3'b0, PAIR_VLD}, 4'h1);
        check("t2_err", {3'b0, ERR}, 4'h0);
        idle(1);
        #1 check("t2_pv_pulse", {3'b0, PAIR_VLD}, 4'h0);

        // 3: disable gating and dropped partial pair
        step(1, 4'h0, 0, 0, 0, 0);
        #1;
        check("t3_qa_gated", QA, 4'h0);
        check("t3_qb_gated", QB, 4'h0);
        step(0, 4'h0, 0, 0, 0, 0);
        #1;
        check("t3_qa_back", QA, 4'b1010);
        check("t3_qb_back", QB, 4'b0101);
        step(0, 4'hE, 1, 1, 0, 0);
        step(1, 4'h1, 1, 0, 0, 0);
        #1;
        check("t3_phase", {3'b0, PHASE}, 4'h0);
        check("t3_err", {3'b0, ERR}, 4'h0);
        step(0, 4'h0, 0, 0, 0, 0);
        #1;
        check("t3_no_pair", {3'b0, PAIR_VLD}, 4'h0);
        check("t3_qa_kept", QA, 4'b1010);

        // 4: double A, new A wins
        step(0, 4'h3, 1, 1, 0, 0);
        step(0, 4'hC, 1, 1, 0, 0);
        #1 check("t4_err_set", {3'b0, ERR}, 4'h1);
        step(0, 4'h6, 1, 0, 0, 0);
        #1;
        check("t4_qa", QA, 4'hC);
        check("t4_qb", QB, 4'h6);
        check("t4_pv", {3'b0, PAIR_VLD}, 4'h1);
        idle(2);
        #1 check("t4_err_sticky", {3'b0, ERR}, 4'h1);
        step(0, 4'h0, 0, 0, 1, 0);
        #1 check("t4_err_clr", {3'b0, ERR}, 4'h0);

        // 5: timeout after TIMEOUT+1 idle cycles
        step(0, 4'h9, 1, 1, 0, 0);
        idle(TIMEOUT);
        #1;
        check("t5_phase_hold", {3'b0, PHASE}, 4'h1);
        check("t5_err_before", {3'b0, ERR}, 4'h0);
        idle(1);
        #1;
        check("t5_phase_abort", {3'b0, PHASE}, 4'h0);
        check("t5_err", {3'b0, ERR}, 4'h1);
        check("t5_qa", QA, 4'hC);
        step(0, 4'h2, 1, 0, 0, 0);
        #1;
        check("t5_qb_kept", QB, 4'h6);
        check("t5_err_stays", {3'b0, ERR}, 4'h1);

        // 6: stray B races ERR_CLR, set wins
        step(0, 4'h0, 0, 0, 1, 0);
        #1 check("t6_pre_clr", {3'b0, ERR}, 4'h0);
        step(0, 4'h7, 1, 0, 1, 0);
        #1 check("t6_race", {3'b0, ERR}, 4'h1);

        // Asynchronous reset mid-pair
        step(0, 4'h5, 1, 1, 0, 0);
        @(negedge CLK);
        #2;
        chk_en = 1'b0;
        RST = 1'b1;
        #1;
        check("arst_phase", {3'b0, PHASE}, 4'h0);
        check("arst_qa", QA, 4'h0);
        check("arst_err", {3'b0, ERR}, 4'h0);
        model_reset();
        chk_en = 1'b1;
        step(0, 4'h0, 0, 0, 0, 1);

        // Random traffic, with segments of sparse valids to reach the timeout
        for (int seg = 0; seg < 12; seg++) begin
            int vld_pct;
            vld_pct = (seg % 3 == 2) ? 4 : $urandom_range(30, 90);
            for (int i = 0; i < 60; i++) begin
                step(($urandom_range(0, 99) < 8),
                     WIDTH'($urandom),
                     ($urandom_range(0, 99) < vld_pct),
                     ($urandom_range(0, 99) < 55),
                     ($urandom_range(0, 99) < 6),
                     ($urandom_range(0, 999) < 3));
            end
        end
        idle(2);
        @(negedge CLK);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
